// File: rtl/timer_ctrl.sv
// timer_ctrl: BCD mm:ss count-down/count-up timer with run/pause/done control.
// Optional define TIMER_CTRL_ALARM_BLINK_EN makes the alarm light blink once per tick in DONE.
module timer_ctrl #(
  parameter int LIGHT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_pb,
  input  logic               clear_pb,
  input  logic               mode,
  input  logic               tick,
  input  logic [3:0]         pre_min1,
  input  logic [3:0]         pre_min0,
  input  logic [3:0]         pre_sec1,
  input  logic [3:0]         pre_sec0,
  output logic [3:0]         min1,
  output logic [3:0]         min0,
  output logic [3:0]         sec1,
  output logic [3:0]         sec0,
  output logic [1:0]         state,
  output logic               alarm,
  output logic [LIGHT_W-1:0] light
);
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d, pre_q, pre_d, preset, inc, dec, step;
  logic        mode_q, mode_d, valid, hit, blink;
  assign preset = {pre_min1, pre_min0, pre_sec1, pre_sec0};
  assign valid  = pre_min1 <= 4'd9 && pre_min0 <= 4'd9 && pre_sec1 <= 4'd5 && pre_sec0 <= 4'd9;
  // BCD increment wraps 59:59 -> 00:00; decrement borrows through each digit
  always_comb begin
    logic c0, c1, c2, b0, b1, b2;
    c0 = cnt_q[3:0] == 4'd9;
    c1 = c0 && cnt_q[7:4] == 4'd5;
    c2 = c1 && cnt_q[11:8] == 4'd9;
    inc[3:0]   = c0 ? 4'd0 : cnt_q[3:0] + 4'd1;
    inc[7:4]   = c0 ? (cnt_q[7:4] == 4'd5 ? 4'd0 : cnt_q[7:4] + 4'd1) : cnt_q[7:4];
    inc[11:8]  = c1 ? (cnt_q[11:8] == 4'd9 ? 4'd0 : cnt_q[11:8] + 4'd1) : cnt_q[11:8];
    inc[15:12] = c2 ? (cnt_q[15:12] == 4'd5 ? 4'd0 : cnt_q[15:12] + 4'd1) : cnt_q[15:12];
    b0 = cnt_q[3:0] == 4'd0;
    b1 = b0 && cnt_q[7:4] == 4'd0;
    b2 = b1 && cnt_q[11:8] == 4'd0;
    dec[3:0]   = b0 ? 4'd9 : cnt_q[3:0] - 4'd1;
    dec[7:4]   = b0 ? (cnt_q[7:4] == 4'd0 ? 4'd5 : cnt_q[7:4] - 4'd1) : cnt_q[7:4];
    dec[11:8]  = b1 ? (cnt_q[11:8] == 4'd0 ? 4'd9 : cnt_q[11:8] - 4'd1) : cnt_q[11:8];
    dec[15:12] = b2 ? (cnt_q[15:12] == 4'd0 ? 4'd5 : cnt_q[15:12] - 4'd1) : cnt_q[15:12];
  end
  assign step = mode_q ? inc : dec;
  assign hit  = mode_q ? (pre_q != 16'd0 && inc == pre_q) : dec == 16'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (clear_pb) state_d = IDLE;
    else if (state_q == IDLE)
      state_d = start_pb && valid && (mode || preset != 16'd0) ? RUN : IDLE;
    else if (state_q == RUN)
      state_d = tick && hit ? DONE : start_pb ? PAUSE : RUN;
    else if (state_q == PAUSE)
      state_d = start_pb ? RUN : PAUSE;
    else
      state_d = start_pb ? IDLE : DONE;
  end
  always_comb begin
    cnt_d  = (state_q == IDLE || state_d == IDLE) ? (mode ? 16'd0 : preset)
           : (state_q == RUN && tick) ? step : cnt_q;
    pre_d  = state_q == IDLE ? preset : pre_q;
    mode_d = state_q == IDLE ? mode : mode_q;
  end
`ifdef TIMER_CTRL_ALARM_BLINK_EN
  logic blink_q, blink_d;
  // Phase is forced to 0 outside DONE so every DONE entry starts lit
  assign blink_d = state_q != DONE ? 1'b0 : blink_q ^ tick;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_q <= 1'b0;
    else     blink_q <= blink_d;
  end
  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif
  always_comb begin
    {min1, min0, sec1, sec0} = cnt_q;
    state = state_q;
    alarm = state_q == DONE;
    light = alarm && !blink ? '1 : '0;
  end
endmodule
